if_fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined CPU. Holds the program counter and drives the word-aligned fetch address into the combinational instruction memory. Latches the returned instruction and PC+4 into the IF/ID pipeline register. Honours hazard-unit stalls and branch/jump redirects, and halts cleanly when the PC leaves the populated instruction space.

---
 rtl/if_fetch_stage_pkg.sv | 18 +
 rtl/if_fetch_stage_if_id_reg.sv | 37 +++
 rtl/if_fetch_stage.sv | 88 ++++++++
 tb/tb_if_fetch_stage.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared CPU constants and types for the fetch stage and its IF/ID register.
package if_fetch_stage_pkg;

  localparam int          DATA_W           = 32;
  localparam int          WORD_BYTES       = 4;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
    return {addr[DATA_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold, insert a bubble or flush.
module if_id_reg
  import if_fetch_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic              bubble,
  input  logic [DATA_W-1:0] next_pc_plus4,
  input  logic [DATA_W-1:0] next_instr,
  output logic [DATA_W-1:0] pc_plus4,
  output logic [DATA_W-1:0] instr,
  output logic              valid
);

  // flush clears everything; bubble only invalidates the instruction slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_plus4 <= '0;
      instr    <= INSTR_NOP;
      valid    <= 1'b0;
    end else if (flush) begin
      pc_plus4 <= '0;
      instr    <= INSTR_NOP;
      valid    <= 1'b0;
    end else if (bubble) begin
      instr    <= INSTR_NOP;
      valid    <= 1'b0;
    end else if (load) begin
      pc_plus4 <= next_pc_plus4;
      instr    <= next_instr;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, redirect/stall/halt priority, fetch counter.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          IMEM_WORDS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] pc_o,
  input  logic [31:0] instr_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] ifid_pc_plus4_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o,
  output logic        halted_o,
  output logic        misalign_o,
  output logic [31:0] fetch_cnt_o
);

  localparam logic [DATA_W-1:0] PC_LIMIT = DATA_W'(IMEM_WORDS * WORD_BYTES);
  localparam logic [DATA_W-1:0] PC_STEP  = DATA_W'(WORD_BYTES);

  fetch_state_e      state_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] fetch_cnt_q;
  logic              misalign_q;
  logic              oob;
  logic              ifid_load;
  logic              ifid_flush;
  logic              ifid_bubble;

  assign pc_plus4 = pc_q + PC_STEP;
  assign oob      = (pc_q >= PC_LIMIT);

  // Control priority: redirect > stall > halted/oob bubble > normal fetch.
  assign ifid_flush  = redirect_i;
  assign ifid_bubble = !redirect_i && !stall_i && ((state_q == ST_HALT) || oob);
  assign ifid_load   = !redirect_i && !stall_i && (state_q == ST_RUN) && !oob;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      fetch_cnt_q <= '0;
      misalign_q  <= 1'b0;
    end else if (redirect_i) begin
      state_q    <= ST_RUN;
      pc_q       <= word_align(redirect_target_i);
      misalign_q <= misalign_q | (redirect_target_i[1:0] != 2'b00);
    end else if (!stall_i) begin
      case (state_q)
        ST_RUN: begin
          if (oob) begin
            state_q <= ST_HALT;
          end else begin
            pc_q        <= pc_plus4;
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
          end
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_RUN;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk           (clk_i),
    .rst_n         (rst_i),
    .load          (ifid_load),
    .flush         (ifid_flush),
    .bubble        (ifid_bubble),
    .next_pc_plus4 (pc_plus4),
    .next_instr    (instr_i),
    .pc_plus4      (ifid_pc_plus4_o),
    .instr         (ifid_instr_o),
    .valid         (ifid_valid_o)
  );

  assign pc_o        = pc_q;
  assign halted_o    = (state_q == ST_HALT);
  assign misalign_o  = misalign_q;
  assign fetch_cnt_o = fetch_cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: fetch, stall, redirect, misalign, halt, async reset.
module tb_if_fetch_stage;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] pc_o;
  logic [31:0] instr_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic [31:0] ifid_pc_plus4_o;
  logic [31:0] ifid_instr_o;
  logic        ifid_valid_o;
  logic        halted_o;
  logic        misalign_o;
  logic [31:0] fetch_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (32)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .pc_o              (pc_o),
    .instr_i           (instr_i),
    .stall_i           (stall_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .ifid_pc_plus4_o   (ifid_pc_plus4_o),
    .ifid_instr_o      (ifid_instr_o),
    .ifid_valid_o      (ifid_valid_o),
    .halted_o          (halted_o),
    .misalign_o        (misalign_o),
    .fetch_cnt_o       (fetch_cnt_o)
  );

  // Clock/reset block.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Instruction memory: word k holds 32'h20080001 + k; out-of-range reads return junk.
  function automatic logic [31:0] word(input int k);
    return 32'h2008_0001 + 32'(k);
  endfunction

  assign instr_i = (pc_o < 32'd128) ? (32'h2008_0001 + 32'(pc_o[6:2])) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] pp4, input logic valid, input logic [31:0] cnt,
                           input logic halted, input logic mis);
    check({tag, ".pc"},       pc_o,                  pc);
    check({tag, ".instr"},    ifid_instr_o,          instr);
    check({tag, ".pc_plus4"}, ifid_pc_plus4_o,       pp4);
    check({tag, ".valid"},    32'(ifid_valid_o),     32'(valid));
    check({tag, ".cnt"},      fetch_cnt_o,           cnt);
    check({tag, ".halted"},   32'(halted_o),         32'(halted));
    check({tag, ".misalign"}, 32'(misalign_o),       32'(mis));
  endtask

  // Driver: advance one clock and sample 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i             = 1'b0;
    stall_i           = 1'b0;
    redirect_i        = 1'b0;
    redirect_target_i = 32'h0;
    repeat (2) @(posedge clk_i);
    #1;
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0);

    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("release.pc", pc_o, 32'h0);

    step(); check_all("run0", 32'd4, word(0), 32'd4, 1'b1, 32'd1, 1'b0, 1'b0);
    step(); check_all("run1", 32'd8, word(1), 32'd8, 1'b1, 32'd2, 1'b0, 1'b0);

    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_all("stall", 32'd8, word(1), 32'd8, 1'b1, 32'd2, 1'b0, 1'b0);
    end
    stall_i = 1'b0;
    step(); check_all("run2", 32'd12, word(2), 32'd12, 1'b1, 32'd3, 1'b0, 1'b0);
    step(); check_all("run3", 32'd16, word(3), 32'd16, 1'b1, 32'd4, 1'b0, 1'b0);

    // Redirect overrides a simultaneous stall.
    redirect_i = 1'b1; redirect_target_i = 32'h14; stall_i = 1'b1;
    step(); check_all("redir_stall", 32'h14, 32'h0, 32'h0, 1'b0, 32'd4, 1'b0, 1'b0);
    redirect_i = 1'b0; stall_i = 1'b0;
    step(); check_all("after_redir", 32'h18, word(5), 32'h18, 1'b1, 32'd5, 1'b0, 1'b0);

    redirect_i = 1'b1; redirect_target_i = 32'h1E;
    step(); check_all("misalign", 32'h1C, 32'h0, 32'h0, 1'b0, 32'd5, 1'b0, 1'b1);
    redirect_i = 1'b0;
    step(); check_all("after_mis", 32'h20, word(7), 32'h20, 1'b1, 32'd6, 1'b0, 1'b1);

    redirect_i = 1'b1; redirect_target_i = 32'h8;
    step(); check_all("redir_sticky", 32'h8, 32'h0, 32'h0, 1'b0, 32'd6, 1'b0, 1'b1);
    redirect_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check_all("run_to40", 32'(8 + 4 * i), word(1 + i), 32'(8 + 4 * i), 1'b1, 32'(6 + i), 1'b0, 1'b1);
    end

    // Asynchronous reset between edges while pc=40.
    #2;
    rst_i = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("rerelease.pc", pc_o, 32'h0);

    for (int k = 0; k < 32; k++) begin
      step();
      check_all("run_end", 32'(4 * k + 4), word(k), 32'(4 * k + 4), 1'b1, 32'(k + 1), 1'b0, 1'b0);
    end

    // Stall while out of range: no halt yet.
    stall_i = 1'b1;
    step(); check_all("stall_oob", 32'd128, word(31), 32'd128, 1'b1, 32'd32, 1'b0, 1'b0);
    stall_i = 1'b0;

    for (int i = 0; i < 2; i++) begin
      step();
      check("halt.pc",     pc_o,               32'd128);
      check("halt.instr",  ifid_instr_o,       32'h0);
      check("halt.valid",  32'(ifid_valid_o),  32'd0);
      check("halt.cnt",    fetch_cnt_o,        32'd32);
      check("halt.halted", 32'(halted_o),      32'd1);
    end

    redirect_i = 1'b1; redirect_target_i = 32'h0;
    step(); check_all("unhalt", 32'h0, 32'h0, 32'h0, 1'b0, 32'd32, 1'b0, 1'b0);
    redirect_i = 1'b0;
    step(); check_all("refetch0", 32'd4, word(0), 32'd4, 1'b1, 32'd33, 1'b0, 1'b0);

    // Redirect to an out-of-range target is taken, then halts.
    redirect_i = 1'b1; redirect_target_i = 32'h200;
    step(); check_all("redir_oob", 32'h200, 32'h0, 32'h0, 1'b0, 32'd33, 1'b0, 1'b0);
    redirect_i = 1'b0;
    step();
    check("oob_halt.pc",     pc_o,              32'h200);
    check("oob_halt.valid",  32'(ifid_valid_o), 32'd0);
    check("oob_halt.instr",  ifid_instr_o,      32'h0);
    check("oob_halt.halted", 32'(halted_o),     32'd1);
    check("oob_halt.cnt",    fetch_cnt_o,       32'd33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
